// File: rtl/monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : monitor_pkg
// Brief    : Shared types and constants for the monitor channel-load path.
// Revision : 1.0  initial release
// ============================================================================
package monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_WT = 3'd2,
        ST_STROBE  = 3'd3,
        ST_RELEASE = 3'd4
    } mon_state_t;

    localparam logic [8:0]  c_CH_MIN   = 9'o001;
    localparam logic [8:0]  c_CH_MAX   = 9'o077;
    localparam logic [15:0] c_CLR_ADDR = 16'h0000;

    localparam int c_ST_ERR_TMO = 15;
    localparam int c_ST_ERR_OVF = 14;
    localparam int c_ST_FULL    = 4;
    localparam int c_ST_EMPTY   = 3;
    localparam int c_ST_CNT_LSB = 0;

    // Occupancy as reported in status: saturates so it fits three bits.
    function automatic logic [2:0] sat_count(input logic [4:0] n);
        return (n > 5'd7) ? 3'd7 : n[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mon_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mon_sync_fifo
// Brief    : Synchronous FIFO, wrap-around pointers, simultaneous push/pop.
// Revision : 1.0  initial release
// ============================================================================
module mon_sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // A pop frees the head slot this cycle, so a push into a full FIFO still fits.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/monitor_chan_writer.sv
`default_nettype none
// ============================================================================
// Module   : monitor_chan_writer
// Brief    : Queues host channel writes and loads them via req/grant + monwt.
// Revision : 1.0  initial release
// ============================================================================
module monitor_chan_writer
    import monitor_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        monwt,
    input  logic        mload_grant,
    output logic        mload_req,
    output logic [8:0]  mload_ch,
    output logic [14:0] mload_data,
    output logic        mload_wr,
    output logic [15:0] status
);
    localparam int unsigned c_CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned c_TMO_W = $clog2(TIMEOUT) + 1;

    mon_state_t          r_state;
    mon_state_t          w_next;
    logic                w_ch_write;
    logic                w_clr;
    logic                w_pop;
    logic                w_load;
    logic                w_tmo_fire;
    logic                w_wr;
    logic                w_in_xfer;
    logic                w_tmo_hit;
    logic                w_overflow;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;
    logic [23:0]         w_head;
    logic [c_TMO_W-1:0]  r_tmo;
    logic                r_req;
    logic [8:0]          r_ch;
    logic [14:0]         r_data;
    logic                r_err_tmo;
    logic                r_err_ovf;
    logic [15:0]         r_status;
    logic [15:0]         w_status_nx;
    logic                w_unused_data_msb;

    assign w_unused_data_msb = data_in[15];

    assign w_ch_write = write_en && (addr[15:9] == 7'd0) &&
                        (addr[8:0] >= c_CH_MIN) && (addr[8:0] <= c_CH_MAX);
    assign w_clr      = write_en && (addr == c_CLR_ADDR) && data_in[0];
    assign w_overflow = w_ch_write && w_full && !w_pop;
    assign w_tmo_hit  = (r_tmo == c_TMO_W'(TIMEOUT - 1));

    mon_sync_fifo #(
        .WIDTH (24),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_ch_write),
        .pop   (w_pop),
        .wdata ({addr[8:0], data_in[14:0]}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (!w_empty)     w_next = ST_REQ;
            ST_REQ:     if (mload_grant)  w_next = ST_WAIT_WT;
                        else if (w_tmo_hit) w_next = ST_IDLE;
            ST_WAIT_WT: if (monwt)        w_next = ST_STROBE;
            ST_STROBE:                    w_next = ST_RELEASE;
            ST_RELEASE: if (!mload_grant) w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load     = (r_state == ST_IDLE) && !w_empty;
        w_tmo_fire = (r_state == ST_REQ) && !mload_grant && w_tmo_hit;
        w_wr       = (r_state == ST_STROBE);
        w_pop      = w_wr || w_tmo_fire;
        w_in_xfer  = (r_state == ST_REQ) || (r_state == ST_WAIT_WT) ||
                     (r_state == ST_STROBE);
    end

    // The request is registered from state, so it trails entry/exit by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo     <= '0;
            r_req     <= 1'b0;
            r_ch      <= '0;
            r_data    <= '0;
            r_err_tmo <= 1'b0;
            r_err_ovf <= 1'b0;
            r_status  <= 16'h0008;
        end else begin
            r_req <= w_in_xfer;
            if (w_load) begin
                r_tmo  <= '0;
                r_ch   <= w_head[23:15];
                r_data <= w_head[14:0];
            end else if (r_state == ST_REQ) begin
                r_tmo  <= r_tmo + c_TMO_W'(1);
            end
            // A new error in the same cycle as a clear write is kept.
            if (w_clr) begin
                r_err_tmo <= 1'b0;
                r_err_ovf <= 1'b0;
            end
            if (w_tmo_fire) r_err_tmo <= 1'b1;
            if (w_overflow) r_err_ovf <= 1'b1;
            r_status <= w_status_nx;
        end
    end

    always_comb begin
        w_status_nx                       = '0;
        w_status_nx[c_ST_ERR_TMO]         = r_err_tmo;
        w_status_nx[c_ST_ERR_OVF]         = r_err_ovf;
        w_status_nx[c_ST_FULL]            = w_full;
        w_status_nx[c_ST_EMPTY]           = w_empty;
        w_status_nx[c_ST_CNT_LSB +: 3]    = sat_count(5'(w_count));
    end

    assign mload_req  = r_req;
    assign mload_ch   = r_ch;
    assign mload_data = r_data;
    assign mload_wr   = w_wr;
    assign status     = r_status;

endmodule
`default_nettype wire

// File: tb/tb_monitor_chan_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_monitor_chan_writer
// Brief    : Directed + randomized bench with an in-bench behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_monitor_chan_writer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_en = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        monwt = 1'b0;
    logic        mload_grant = 1'b0;
    logic        mload_req;
    logic [8:0]  mload_ch;
    logic [14:0] mload_data;
    logic        mload_wr;
    logic [15:0] status;

    int total = 0;
    int bad   = 0;

    monitor_chan_writer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .write_en    (write_en),
        .addr        (addr),
        .data_in     (data_in),
        .monwt       (monwt),
        .mload_grant (mload_grant),
        .mload_req   (mload_req),
        .mload_ch    (mload_ch),
        .mload_data  (mload_data),
        .mload_wr    (mload_wr),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_ASK = 1, P_HELD = 2, P_FIRE = 3, P_DRAIN = 4;
    logic [23:0] q[$];
    int          phase = P_IDLE;
    int          asked = 0;       // cycles spent asking without a grant
    bit          m_live = 0;
    bit          m_req = 0;
    bit          m_etmo = 0, m_eovf = 0;
    logic [8:0]  m_ch = '0;
    logic [14:0] m_data = '0;
    logic [15:0] m_status = 16'h0008;

    function automatic logic [15:0] mstat(int n, bit et, bit eo);
        logic [2:0] c;
        c = (n > 7) ? 3'd7 : 3'(n);
        return {et, eo, 9'b0, (n == DEPTH), (n == 0), c};
    endfunction

    always @(posedge clk) begin : mdl
        bit push, clr, drop, timed_out;
        int n;
        if (rst) begin
            q.delete();
            phase = P_IDLE; asked = 0; m_live = 1;
            m_req = 0; m_etmo = 0; m_eovf = 0;
            m_ch = '0; m_data = '0; m_status = 16'h0008;
        end else begin
            n         = q.size();
            m_status  = mstat(n, m_etmo, m_eovf);
            m_req     = (phase == P_ASK) || (phase == P_HELD) || (phase == P_FIRE);
            push      = write_en && (addr[15:9] == 0) && (addr[8:0] >= 1) && (addr[8:0] <= 63);
            clr       = write_en && (addr == 0) && data_in[0];
            drop      = 0;
            timed_out = 0;
            if (phase == P_IDLE) begin
                if (n > 0) begin
                    m_ch = q[0][23:15]; m_data = q[0][14:0];
                    phase = P_ASK; asked = 0;
                end
            end else if (phase == P_ASK) begin
                if (mload_grant) phase = P_HELD;
                else begin
                    asked++;
                    if (asked == TIMEOUT) begin drop = 1; timed_out = 1; phase = P_IDLE; end
                end
            end else if (phase == P_HELD) begin
                if (monwt) phase = P_FIRE;
            end else if (phase == P_FIRE) begin
                drop = 1; phase = P_DRAIN;
            end else begin
                if (!mload_grant) phase = P_IDLE;
            end
            if (clr) begin m_etmo = 0; m_eovf = 0; end
            if (timed_out) m_etmo = 1;
            if (push && n == DEPTH && !drop) m_eovf = 1;
            if (drop) void'(q.pop_front());
            if (push && !(n == DEPTH && !drop)) q.push_back({addr[8:0], data_in[14:0]});
        end
    end

    always begin
        @(posedge clk); #1;
        if (m_live) begin
            chk("req",    mload_req,  m_req);
            chk("wr",     mload_wr,   phase == P_FIRE);
            chk("ch",     mload_ch,   m_ch);
            chk("data",   mload_data, m_data);
            chk("status", status,     m_status);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic hw(input logic [15:0] a, input logic [15:0] d);
        write_en = 1'b1; addr = a; data_in = d;
        cyc();
        write_en = 1'b0; addr = '0; data_in = '0;
    endtask

    task automatic service(input string nm, output logic [8:0] ch_seen);
        int i;
        ch_seen = '0;
        i = 0;
        while (!mload_req && i < 40) begin cyc(); i++; end
        chk({nm, " req"}, mload_req, 1);
        mload_grant = 1'b1; cyc();
        monwt = 1'b1; cyc();
        chk({nm, " wr"}, mload_wr, 1);
        ch_seen = mload_ch;
        monwt = 1'b0; mload_grant = 1'b0;
        cyc(3);
    endtask

    initial begin
        logic [8:0] chs;
        int wr_cnt;
        cyc(3);
        chk("reset status", status, 16'h0008);
        chk("reset req", mload_req, 0);
        rst = 1'b0;
        cyc(2);

        // single load with literal timing
        write_en = 1'b1; addr = 16'o012; data_in = 16'o077;
        cyc();
        write_en = 1'b0;
        chk("t1 req k", mload_req, 0);
        cyc();
        chk("t1 req k+1", mload_req, 0);
        cyc();
        chk("t1 req k+2", mload_req, 1);
        chk("t1 ch", mload_ch, 9'o012);
        chk("t1 data", mload_data, 15'o077);
        chk("t1 status", status, 16'h0001);
        cyc(3); mload_grant = 1'b1;
        cyc(5); monwt = 1'b1;
        cyc();
        chk("t1 wr", mload_wr, 1);
        monwt = 1'b0; mload_grant = 1'b0;
        cyc();
        chk("t1 wr once", mload_wr, 0);
        chk("t1 req m+1", mload_req, 1);
        cyc();
        chk("t1 req m+2", mload_req, 0);
        cyc(3);
        chk("t1 status end", status, 16'h0008);

        // overflow
        for (int i = 1; i <= 5; i++) hw(16'(i), 16'(100 + i));
        cyc();
        chk("t2 overflow status", status, 16'h4014);
        for (int i = 1; i <= 4; i++) begin
            service("t2", chs);
            chk("t2 order", chs, 9'(i));
        end
        cyc(10);
        chk("t2 no fifth", mload_req, 0);
        chk("t2 status", status, 16'h4008);

        // timeout then clear
        hw(16'o020, 16'h1111);
        hw(16'o021, 16'h2222);
        cyc(20);
        chk("t3 err_timeout", status[15], 1);
        chk("t3 next req", mload_req, 1);
        chk("t3 next ch", mload_ch, 9'o021);
        service("t3", chs);
        hw(16'h0000, 16'h0001);
        cyc(2);
        chk("t3 cleared", status, 16'h0008);

        // grant held across two entries
        mload_grant = 1'b1;
        hw(16'o030, 16'h0030);
        hw(16'o031, 16'h0031);
        wr_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            monwt = (i % 3 == 0); cyc();
            if (mload_wr) wr_cnt++;
        end
        chk("t4 one strobe per grant", wr_cnt, 1);
        chk("t4 no rerequest", mload_req, 0);
        mload_grant = 1'b0; monwt = 1'b0; cyc(2);
        mload_grant = 1'b1;
        for (int i = 0; i < 30; i++) begin
            monwt = (i % 3 == 0); cyc();
            if (mload_wr) wr_cnt++;
        end
        chk("t4 second strobe", wr_cnt, 2);
        mload_grant = 1'b0; monwt = 1'b0; cyc(3);

        // reset during WAIT_WT, then ignored writes
        hw(16'o040, 16'h0040);
        for (int i = 0; i < 10 && !mload_req; i++) cyc();
        mload_grant = 1'b1; cyc(2);
        rst = 1'b1; monwt = 1'b1; cyc();
        chk("t5 rst req", mload_req, 0);
        chk("t5 rst wr", mload_wr, 0);
        chk("t5 rst ch", mload_ch, 0);
        chk("t5 rst status", status, 16'h0008);
        rst = 1'b0; monwt = 1'b0; mload_grant = 1'b0;
        hw(16'o100, 16'h1234);
        hw(16'h0000, 16'h0000);
        hw(16'h0201, 16'h5555);
        cyc(3);
        chk("t5 ignored", status, 16'h0008);
        chk("t5 ignored req", mload_req, 0);

        // push and pop together while full
        for (int i = 0; i < 4; i++) hw(16'(8 + i), 16'(i));
        cyc();
        mload_grant = 1'b1; cyc();
        monwt = 1'b1; cyc();
        monwt = 1'b0; mload_grant = 1'b0;
        hw(16'o055, 16'h0055);
        cyc();
        chk("t6 full push+pop", status, 16'h0014);

        // randomized traffic
        for (int ep = 0; ep < 15; ep++) begin
            int gp;
            gp = (ep % 4 == 0) ? 0 : $urandom_range(20, 100);
            for (int i = 0; i < 200; i++) begin
                int r;
                r = $urandom_range(0, 99);
                write_en = (r < 35);
                if ($urandom_range(0, 9) < 6)      addr = 16'($urandom_range(1, 63));
                else if ($urandom_range(0, 2) == 0) addr = 16'h0000;
                else                                addr = 16'($urandom);
                data_in     = 16'($urandom);
                mload_grant = ($urandom_range(0, 99) < gp);
                monwt       = ($urandom_range(0, 3) == 0);
                rst         = ($urandom_range(0, 599) == 0);
                cyc();
            end
        end
        write_en = 1'b0; rst = 1'b0; mload_grant = 1'b0; monwt = 1'b0;
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/monitor_chan_writer.md
# monitor_chan_writer

Host-to-AGC channel injection path for the monitor. It accepts host writes addressed to I/O channels and queues them in a small FIFO. For each queued entry it runs a request/grant channel-load handshake with the monitor sequencer and presents the channel number and data word, qualified by a one-cycle strobe aligned to the next `monwt`. It is the write-direction counterpart of the channel-snoop/readback path, and it sits between the host bus decode and the monitor channel-load logic.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TIMEOUT`, 1024: maximum cycles spent in REQ waiting for grant before the entry is dropped.
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `write_en`  in  1  host write strobe, one cycle per write.
- `addr`  in  16  host address; channel number in `addr[8:0]`.
- `data_in`  in  16  host write data; `data_in[14:0]` is the channel word.
- `monwt`  in  1  monitor write-timing pulse from the AGC timing chain.
- `mload_grant`  in  1  sequencer grant; stays high while the AGC is held for the load.
- `mload_req`  out  1  channel-load request.
- `mload_ch`  out  9  channel number; valid while `mload_req` is high.
- `mload_data`  out  15  channel word; valid while `mload_req` is high.
- `mload_wr`  out  1  one-cycle write strobe.
- `status`  out  16  `{err_timeout, err_overflow, 9'b0, full, empty, count[2:0]}`, where `count` saturates at 7.

## Operation
- Host decode:
  - A write with `addr[15:9]==0` and `addr[8:0]` in 0o001..0o077 pushes `{addr[8:0], data_in[14:0]}` into the FIFO.
  - A write to address 0 with `data_in[0]=1` clears both sticky error flags and pushes nothing.
  - All other writes are ignored.
- FIFO:
  - `DEPTH` entries, 24 bits each, first-in first-out, with wrap-around pointers.
  - A push while full, with no pop in the same cycle, is dropped and sets `err_overflow`.
  - A push and pop in the same cycle are both performed, including when the FIFO is full.
- FSM states:
  - IDLE: when the FIFO is non-empty, load its head into the `mload_ch`/`mload_data` registers and go to REQ.
  - REQ: `mload_req=1`. When `mload_grant=1`, go to WAIT_WT. When the timeout counter reaches `TIMEOUT-1`, pop the entry, set `err_timeout`, and go to IDLE.
  - WAIT_WT: `mload_req=1`. On the first cycle with `monwt=1`, go to STROBE.
  - STROBE: `mload_wr=1` and `mload_req=1` for exactly one cycle; pop the entry and go to RELEASE.
  - RELEASE: `mload_req=0`. Stay until `mload_grant=0`, then go to IDLE. This prevents one grant from being reused for two loads.
- The timeout counter clears on entry to REQ. Grant and `monwt` have no timeout once grant has been received.
- `mload_ch`/`mload_data` hold their last value outside REQ..STROBE.
- Reset, including mid-transfer:
  - All outputs go to 0 (`status` reads 16'h0008, i.e. empty=1).
  - The FIFO is flushed, the FSM returns to IDLE, and both error flags clear.
  - An in-flight entry is discarded and no `mload_wr` is emitted.

## Timing
- Host write sampled at edge k into an idle, empty block: `mload_req` is high from edge k+2.
- Grant sampled high at edge g: WAIT_WT from g.
- `monwt` sampled high at edge m: `mload_wr` is high for the single cycle m..m+1, and `mload_req` falls at edge m+2.
- `monwt` already high on the first WAIT_WT cycle: it counts as the trigger.
- `status` is registered and reflects FIFO and flag state one cycle after the event.
- Throughput: at most one load per grant cycle. A back-to-back FIFO entry re-requests one cycle after RELEASE sees grant low.

## Structure
- Shared package `monitor_pkg`: state enum (IDLE, REQ, WAIT_WT, STROBE, RELEASE), the channel-range constants 0o001/0o077, the clear-address constant, and the `status` bit positions.
- Sub-module `mon_sync_fifo`: parameterised width/depth synchronous FIFO with full/empty/count and simultaneous push/pop. The FSM, decode and flags stay in the top module.

## Test plan
- Write 0o077 to ch 0o012; grant after 3 cycles, `monwt` 5 cycles later -> `mload_req` at k+2, `mload_ch`=0o012, `mload_data`=0o077, exactly one `mload_wr` cycle, `status` returns to 16'h0008.
- Four writes (DEPTH=4) then a fifth while stalled without grant -> fifth dropped, `err_overflow`=1, `count`=4, full=1. Then service all four -> loads in order, no fifth load.
- No grant for `TIMEOUT` cycles -> `mload_req` drops, `err_timeout`=1, next entry requested. Write 1 to address 0 -> both flags 0.
- Grant held high across two queued entries -> second `mload_req` rises only after grant goes low then high again, giving one strobe per grant.
- `rst` asserted during WAIT_WT -> next cycle all outputs 0, no `mload_wr`, FIFO empty. Writes to 0o100, 0o000 with `data_in[0]=0`, and `addr[15:9]!=0` -> no push.
- Push and pop in the same cycle while full -> count stays 4, no overflow flag.
